// File: rtl/seq_detector_param_if.sv
// Bus bundle for the serial pattern detector: configuration, serial input
// stream and the registered detection outputs.
interface seq_detector_param_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  // Configuration, sampled only while load is high
  logic             load;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;

  // Serial stream
  logic             in_valid;
  logic             in_seq;

  // Detection results
  logic             out_seq;
  logic [CNT_W-1:0] match_count;
  logic             armed;

  // Stimulus side: drives configuration and stream, observes results
  modport master (
    output load, pattern, pat_len, overlap, in_valid, in_seq,
    input  out_seq, match_count, armed
  );

  // Detector side
  modport slave (
    input  load, pattern, pat_len, overlap, in_valid, in_seq,
    output out_seq, match_count, armed
  );
endinterface

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loaded pattern of 1..PAT_W bits.
// Each qualified bit is shifted into a history register; when the newest
// len bits equal the pattern a one-cycle pulse is emitted and a saturating
// match counter advances. Overlapping mode keeps the history after a match,
// non-overlapping mode discards it so the matching bits are not reused.
module seq_detector_param #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             overlap_q, overlap_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_q, out_d;

  // Derived per-bit values shared by the next-state logic
  logic [PAT_W-1:0] hist_shift;
  logic [LEN_W-1:0] fill_inc;
  logic [PAT_W-1:0] len_mask;
  logic             enough_bits;
  logic             hit;
  logic             load_ok;
  logic [LEN_W-1:0] len_clamped;

  // A load with zero length carries no pattern and is treated as absent
  assign load_ok     = bus.load && (bus.pat_len != '0);
  assign len_clamped = (bus.pat_len > MAX_LEN) ? MAX_LEN : bus.pat_len;

  // History as it would look after accepting the current bit; the oldest
  // bit falls off the top
  assign hist_shift  = (hist_q << 1) | PAT_W'(bus.in_seq);

  // Fill count saturates at PAT_W: beyond that every length is satisfied
  assign fill_inc    = (fill_q == MAX_LEN) ? MAX_LEN : (fill_q + LEN_W'(1));
  assign enough_bits = (fill_inc >= len_q);

  // Only the lowest len bits take part in the comparison
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign len_mask[gi] = (LEN_W'(gi) < len_q);
  end

  assign hit = enough_bits && ~|((hist_shift ^ pattern_q) & len_mask);

  // State register with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      out_q     <= out_d;
    end
  end

  // Next-state: load has priority over bit acceptance; bubbles hold state
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    count_d   = count_q;
    out_d     = 1'b0;

    if (load_ok) begin
      state_d   = FILL;
      pattern_d = bus.pattern;
      len_d     = len_clamped;
      overlap_d = bus.overlap;
      hist_d    = '0;
      fill_d    = '0;
      count_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // No pattern yet: the stream is ignored
        end
        FILL, HUNT: begin
          if (bus.in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (hit) begin
              out_d = 1'b1;
              if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_W'(1);
              end
              if (overlap_q) begin
                state_d = HUNT;
              end else begin
                // The completing bit is consumed by this match
                hist_d  = '0;
                fill_d  = '0;
                state_d = FILL;
              end
            end else if (enough_bits) begin
              state_d = HUNT;
            end else begin
              state_d = FILL;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.out_seq     = out_q;
  assign bus.match_count = count_q;
  assign bus.armed       = (state_q != IDLE);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: two detectors (8-bit and 2-bit counters)
// share one stimulus stream. Every clocked step pushes the expected outputs
// from a bit-list reference model into a queue; a monitor on the falling
// edge pops and compares.
module tb_seq_detector_param;
  localparam int PAT_W = 5;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;

  seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(8)) bus0 ();
  seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(2)) bus1 ();

  assign bus1.load     = bus0.load;
  assign bus1.pattern  = bus0.pattern;
  assign bus1.pat_len  = bus0.pat_len;
  assign bus1.overlap  = bus0.overlap;
  assign bus1.in_valid = bus0.in_valid;
  assign bus1.in_seq   = bus0.in_seq;

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(8)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       out;
    bit [7:0] c0;
    bit [1:0] c1;
    bit       armed;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: list of accepted bits since last clear, unbounded count
  bit             m_loaded = 1'b0;
  int             m_len    = 0;
  bit [PAT_W-1:0] m_pat    = '0;
  bit             m_ov     = 1'b0;
  bit             m_bits[$];
  int             m_cnt    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic bit model_match();
    int n;
    n = m_bits.size();
    if (n < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      if (m_bits[n - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic exp_t mk_exp(input bit hit);
    exp_t e;
    e.out   = hit;
    e.c0    = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
    e.c1    = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    e.armed = m_loaded;
    return e;
  endfunction

  function automatic exp_t model_step(input bit ld, input bit [PAT_W-1:0] pat,
                                      input bit [LEN_W-1:0] plen, input bit ov,
                                      input bit v, input bit b);
    bit hit;
    hit = 1'b0;
    if (ld && plen != 0) begin
      m_loaded = 1'b1;
      m_len    = (int'(plen) > PAT_W) ? PAT_W : int'(plen);
      m_pat    = pat;
      m_ov     = ov;
      m_bits.delete();
      m_cnt    = 0;
    end else if (m_loaded && v) begin
      m_bits.push_back(b);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      if (model_match()) begin
        hit = 1'b1;
        m_cnt++;
        if (!m_ov) m_bits.delete();
      end
    end
    return mk_exp(hit);
  endfunction

  // One clock of stimulus; expectation queued on the sampling edge
  task automatic step(input bit ld, input bit [PAT_W-1:0] pat, input bit [LEN_W-1:0] plen,
                      input bit ov, input bit v, input bit b);
    exp_t e;
    bus0.load     = ld;
    bus0.pattern  = pat;
    bus0.pat_len  = plen;
    bus0.overlap  = ov;
    bus0.in_valid = v;
    bus0.in_seq   = b;
    if (ld)
      $display("txn load pattern=%b pat_len=%0d overlap=%0d in_valid=%0d", pat, plen, ov, v);
    e = model_step(ld, pat, plen, ov, v, b);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic bit_in(input bit b);
    step(1'b0, '0, '0, 1'b0, 1'b1, b);
  endtask

  task automatic bubble();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input bit [PAT_W-1:0] pat, input bit [LEN_W-1:0] plen, input bit ov);
    step(1'b1, pat, plen, ov, 1'b0, 1'b0);
  endtask

  // Asynchronous reset: overrides any not-yet-sampled expectation
  task automatic do_reset();
    exp_t e;
    $display("txn reset");
    reset         = 1'b1;
    bus0.load     = 1'b0;
    bus0.pattern  = '0;
    bus0.pat_len  = '0;
    bus0.overlap  = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.in_seq   = 1'b0;
    m_loaded = 1'b0;
    m_len    = 0;
    m_pat    = '0;
    m_ov     = 1'b0;
    m_bits.delete();
    m_cnt    = 0;
    if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    e = mk_exp(1'b0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compares every registered output of both detectors
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_seq", 32'(bus0.out_seq), 32'(e.out));
      check("match_count8", 32'(bus0.match_count), 32'(e.c0));
      check("armed", 32'(bus0.armed), 32'(e.armed));
      check("out_seq_c2", 32'(bus1.out_seq), 32'(e.out));
      check("match_count2", 32'(bus1.match_count), 32'(e.c1));
      check("armed_c2", 32'(bus1.armed), 32'(e.armed));
    end
  end

  initial begin
    bit [4:0] bits11011;
    int       nrun;
    bits11011 = 5'b11011;

    do_reset();

    // Zero-length load in IDLE must not arm the detector
    load(5'b00001, 3'd0, 1'b1);
    bit_in(1'b1);

    // Overlapping 101
    load(5'b00101, 3'd3, 1'b1);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);

    // Non-overlapping 101, then 0,1 for a second hit
    load(5'b00101, 3'd3, 1'b0);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);

    // Full-width pattern with bubbles between every bit
    load(5'b11011, 3'd5, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      bit_in(bits11011[i]);
      bubble();
    end

    // Oversized length clamps to PAT_W
    load(5'b10011, 3'd7, 1'b1);
    bit_in(1); bit_in(0); bit_in(0); bit_in(1); bit_in(1); bit_in(0);

    // Zero-length load while armed keeps everything
    load(5'b00000, 3'd0, 1'b0);
    bit_in(0); bit_in(1); bit_in(1);

    // Load with a valid bit in the same cycle discards the bit
    step(1'b1, 5'b00001, 3'd1, 1'b1, 1'b1, 1'b1);
    bit_in(0); bit_in(1);

    // Saturation on both counter widths
    load(5'b00001, 3'd1, 1'b1);
    for (int i = 0; i < 6; i++) bit_in(1'b1);
    for (int i = 0; i < 255; i++) bit_in(1'b1);

    // Reset mid-stream loses the pattern; reload works
    load(5'b00101, 3'd3, 1'b1);
    bit_in(1); bit_in(0);
    do_reset();
    bit_in(1);
    load(5'b00101, 3'd3, 1'b1);
    bit_in(1); bit_in(0); bit_in(1);

    // Reset in the same cycle a pulse was due: pulse must vanish
    load(5'b00001, 3'd1, 1'b0);
    bit_in(1);
    do_reset();
    bit_in(1);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      bit [PAT_W-1:0] pat;
      bit [LEN_W-1:0] plen;
      bit ov;
      pat  = PAT_W'($urandom);
      plen = LEN_W'($urandom_range(0, 7));
      ov   = 1'($urandom);
      if (plen == 0) step(1'b1, pat, plen, ov, 1'b0, 1'b0);
      else           step(1'b1, pat, plen, ov, 1'($urandom_range(0, 1)), 1'($urandom));
      nrun = $urandom_range(10, 50);
      for (int k = 0; k < nrun; k++) begin
        bit v;
        bit b;
        v = ($urandom_range(0, 3) != 0);
        b = ($urandom_range(0, 2) != 0) ? pat[$urandom_range(0, PAT_W - 1)] : 1'($urandom);
        step(1'b0, '0, '0, 1'b0, v, b);
      end
      if ($urandom_range(0, 14) == 0) do_reset();
    end

    bus0.load     = 1'b0;
    bus0.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector. It samples one bit per qualified clock on `in_seq` and compares the most recent bits against a runtime-loaded pattern of programmable length (1..PAT_W). It pulses `out_seq` on every match, supports overlapping and non-overlapping detection, and keeps a saturating match count. It replaces the fixed-pattern detectors driven by the `test_fsm`-style stimulus benches and sits directly on a serial bit stream.

## Interface
- PAT_W, 5: maximum pattern length in bits (≥1).
- CNT_W, 8: width of the match counter.
- LEN_W (localparam), clog2(PAT_W+1): width of `pat_len`.

- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  latch `pattern`, `pat_len` and `overlap`; clear history, fill count and match count.
- pattern  in  PAT_W  pattern bits. Bit [pat_len-1] is the first bit received and bit 0 is the last.
- pat_len  in  LEN_W  pattern length, sampled only on `load`.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled only on `load`.
- in_valid  in  1  qualifies `in_seq` for this cycle.
- in_seq  in  1  serial data bit.
- out_seq  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating number of matches since the last load or reset.
- armed  out  1  high when a pattern is loaded (state ≠ IDLE).

## Operation
- **Reset values:** state=IDLE; pattern, len, overlap, history, fill and match_count all 0; out_seq=0; armed=0.
- **States:**
  - IDLE: no pattern; in_valid is ignored.
  - FILL: fewer than len valid bits since the last load or match clear.
  - HUNT: fill ≥ len.
- **Load:**
  - load with pat_len=0 is ignored and leaves all state unchanged.
  - pat_len > PAT_W is clamped to PAT_W.
  - A valid load from any state goes to FILL and clears history, fill and match_count.
  - If load and in_valid are high in the same cycle, load wins and the bit is discarded.
- **Bit acceptance (in_valid=1, state FILL or HUNT):**
  - hist_next = {hist[PAT_W-2:0], in_seq}.
  - fill_next = min(fill+1, PAT_W).
- **Match:** hist_next[len-1:0] == pattern[len-1:0] and fill_next ≥ len. Bits of `pattern` above len-1 are don't-care.
- **On match:**
  - out_seq=1 for the next cycle.
  - match_count increments, saturating at 2^CNT_W-1; it never wraps.
  - overlap=1: history and fill are kept, so the state stays HUNT.
  - overlap=0: history and fill are cleared to 0, so the state returns to FILL. The matching bit is not reused.
- **FILL→HUNT:** when fill_next ≥ len and no non-overlap clear occurs.
- **Bubbles:** in_valid=0 holds history, fill, state and count, and out_seq=0. Gaps in in_valid do not break a partial match.
- **Reset mid-stream:** asynchronous return to reset values. out_seq drops immediately and the pattern is lost, so a new load is required.

## Timing
- Latency: out_seq is asserted in the cycle following the rising edge that samples the completing bit. It is high for exactly one cycle per match.
- Back-to-back matches on consecutive valid bits (e.g. len=1, or overlap with a periodic pattern) give out_seq high on consecutive cycles.
- match_count updates on the same edge that sets out_seq.
- armed goes high on the edge after a valid load.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Overlapping 101:** load pattern=3'b101, len=3, overlap=1; feed 1,0,1,0,1 → out_seq pulses after the 3rd and 5th bits; match_count=2.
- **Non-overlapping 101:** same stream with overlap=0 → single pulse after the 3rd bit; match_count=1. A further 0,1 gives a second pulse after bit 7.
- **Full-width pattern across bubbles:** PAT_W=5, pattern=5'b11011, len=5; send 1,1,0,1,1 with in_valid=0 inserted between every bit → one pulse after the 5th valid bit. No pulse occurs during bubbles.
- **Load edge cases:**
  - load with pat_len=0 → state and armed unchanged.
  - pat_len=7 with PAT_W=5 → behaves as len=5.
  - load asserted together with in_valid=1 → that bit is not counted.
- **Saturation:** CNT_W=2, len=1, pattern=1'b1, feed six 1s → six out_seq pulses; match_count goes 1,2,3,3,3,3.
- **Reset mid-stream:** load 101, feed 1,0, assert reset for one cycle, release, feed 1 → no pulse and armed=0. Reload and feed 1,0,1 → pulse.
